// File: rtl/crc_frame_engine_if.sv
// crc_frame_engine_if: frame/bit handshake and verdict bus of the CRC engine
// `CRC_SHIFTOUT_EN adds the serial CRC shift-out signals
interface crc_frame_engine_if #(parameter int WIDTH = 16);
  logic start, bit_valid, bit_in, frame_end, busy, done, crc_ok;
  logic [WIDTH-1:0] crc;
  logic [15:0] bit_count;
`ifdef CRC_SHIFTOUT_EN
  logic out_req, out_bit, out_valid, out_last;
  modport master (output start, bit_valid, bit_in, frame_end, out_req,
                  input crc, busy, done, crc_ok, bit_count, out_bit, out_valid, out_last);
  modport slave (input start, bit_valid, bit_in, frame_end, out_req,
                 output crc, busy, done, crc_ok, bit_count, out_bit, out_valid, out_last);
`else
  modport master (output start, bit_valid, bit_in, frame_end,
                  input crc, busy, done, crc_ok, bit_count);
  modport slave (input start, bit_valid, bit_in, frame_end,
                 output crc, busy, done, crc_ok, bit_count);
`endif
endinterface

// File: rtl/crc_frame_engine.sv
// crc_frame_engine: serial CRC-5/CRC-16 generator/checker with registered frame verdict
// `CRC_SHIFTOUT_EN adds MSB-first serialisation of the (optionally inverted) CRC
module crc_frame_engine #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = 16'h1021,
  parameter logic [WIDTH-1:0] PRESET = 16'hFFFF,
  parameter logic [WIDTH-1:0] RESIDUE = 16'h1D0F,
  parameter bit INVERT_OUT = 1'b1
) (
  input logic crcclk,
  input logic reset_n,
  crc_frame_engine_if.slave bus
);
  if (WIDTH != 5 && WIDTH != 16) begin : g_bad_width
    $error("crc_frame_engine: WIDTH must be 5 or 16");
  end
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK
`ifdef CRC_SHIFTOUT_EN
    , SHOUT
`endif
  } state_t;
  state_t state;
  logic [WIDTH-1:0] crc;
  logic [15:0] cnt;
  logic busy, done, crc_ok;
  assign bus.crc = crc;
  assign bus.bit_count = cnt;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.crc_ok = crc_ok;
`ifdef CRC_SHIFTOUT_EN
  logic [4:0] idx;
  logic [WIDTH-1:0] shv;
  logic obit, ovalid, olast;
  assign shv = crc << idx;
  assign bus.out_bit = obit;
  assign bus.out_valid = ovalid;
  assign bus.out_last = olast;
`endif
  always_ff @(posedge crcclk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      crc <= PRESET;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      crc_ok <= 1'b0;
`ifdef CRC_SHIFTOUT_EN
      idx <= '0;
      obit <= 1'b0;
      ovalid <= 1'b0;
      olast <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      busy <= 1'b0;
`ifdef CRC_SHIFTOUT_EN
      ovalid <= 1'b0;
      olast <= 1'b0;
`endif
      // start aborts any frame in progress and always wins over out_req
      if (bus.start && state != IDLE + 2'd3) begin
        state <= SHIFT;
        crc <= PRESET;
        cnt <= '0;
        crc_ok <= 1'b0;
        busy <= 1'b1;
      end else
        case (state)
          IDLE: begin
`ifdef CRC_SHIFTOUT_EN
            if (bus.out_req) begin
              state <= SHOUT;
              idx <= '0;
            end
`endif
          end
          SHIFT: begin
            if (bus.bit_valid) begin
              crc <= {crc[WIDTH-2:0], 1'b0} ^ ((bus.bit_in ^ crc[WIDTH-1]) ? POLY : '0);
              if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
            end
            if (bus.frame_end) state <= CHECK;
            busy <= !bus.frame_end;
          end
          CHECK: begin
            done <= 1'b1;
            crc_ok <= (crc == RESIDUE);
            state <= IDLE;
          end
`ifdef CRC_SHIFTOUT_EN
          SHOUT: begin
            ovalid <= 1'b1;
            obit <= shv[WIDTH-1] ^ INVERT_OUT;
            olast <= (idx == 5'(WIDTH-1));
            idx <= idx + 5'd1;
            if (idx == 5'(WIDTH-1)) state <= IDLE;
          end
`endif
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_crc_frame_engine.sv
// tb_crc_frame_engine: table-driven CRC-16 frames with a verdict scoreboard, plus CRC-5,
// abort, back-to-back, reset and (with CRC_SHIFTOUT_EN) shift-out sequences
module tb_crc_frame_engine;
  logic crcclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 crcclk = ~crcclk;
  crc_frame_engine_if #(.WIDTH(16)) if16();
  crc_frame_engine_if #(.WIDTH(5)) if5();
  crc_frame_engine d16 (.crcclk(crcclk), .reset_n(reset_n), .bus(if16.slave));
  crc_frame_engine #(.WIDTH(5), .POLY(5'h09), .PRESET(5'b01001), .RESIDUE(5'h00), .INVERT_OUT(1'b0))
    d5 (.crcclk(crcclk), .reset_n(reset_n), .bus(if5.slave));
  typedef struct {
    logic [87:0] data;
    int nbits;
    int flip;
    bit gaps;
    bit concur;
    logic ok;
    logic [15:0] crc;
  } vec_t;
  typedef struct {
    logic ok;
    logic [15:0] crc;
    logic [15:0] cnt;
  } exp_t;
  localparam logic [71:0] MSG = 72'h313233343536373839;
  exp_t sbq[$];
  exp_t last;
  vec_t tbl[8];
  int tests = 0;
  int failed = 0;
  int done16 = 0;
  int done5 = 0;
  always @(negedge crcclk) begin
    if (if16.done) done16 <= done16 + 1;
    if (if5.done) done5 <= done5 + 1;
  end
  task automatic tick;
    @(posedge crcclk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [15:0] model(input logic [87:0] d, input int n, input int flip);
    logic [15:0] r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      r ^= {d[7'(n - 1 - i)] ^ (i == flip), 15'b0};
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction
  task automatic send(input vec_t v);
    exp_t e;
    e.ok = v.ok;
    e.crc = (v.flip < 0) ? v.crc : model(v.data, v.nbits, v.flip);
    e.cnt = 16'(v.nbits);
    sbq.push_back(e);
    if16.start = 1'b1;
    tick;
    if16.start = 1'b0;
    for (int i = 0; i < v.nbits; i++) begin
      if (v.gaps) repeat ($urandom_range(0, 3)) begin
        if16.bit_valid = 1'b0;
        tick;
      end
      if16.bit_valid = 1'b1;
      if16.bit_in = v.data[7'(v.nbits - 1 - i)] ^ (i == v.flip);
      if16.frame_end = v.concur && (i == v.nbits - 1);
      tick;
    end
    if16.bit_valid = 1'b0;
    if16.bit_in = 1'b0;
    if (!v.concur) begin
      if16.frame_end = 1'b1;
      tick;
    end
    if16.frame_end = 1'b0;
  endtask
  task automatic verdict(input string nm);
    int n = 0;
    int d0 = done16;
    while (!if16.done && n < 8) begin
      tick;
      n++;
    end
    chk({nm, " latency"}, n, 1);
    if (sbq.size() == 0) chk({nm, " scoreboard empty"}, 1, 0);
    else begin
      last = sbq.pop_front();
      chk({nm, " crc_ok"}, if16.crc_ok, last.ok);
      chk({nm, " crc"}, if16.crc, last.crc);
      chk({nm, " bit_count"}, if16.bit_count, last.cnt);
    end
    tick;
    chk({nm, " done pulse"}, done16 - d0, 1);
    chk({nm, " done low"}, if16.done, 0);
  endtask
  task automatic push(input logic ok, input logic [15:0] c, input logic [15:0] n);
    exp_t e;
    e.ok = ok;
    e.crc = c;
    e.cnt = n;
    sbq.push_back(e);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int d;
    logic [15:0] sh;
    {if16.start, if16.bit_valid, if16.bit_in, if16.frame_end} = '0;
    {if5.start, if5.bit_valid, if5.bit_in, if5.frame_end} = '0;
`ifdef CRC_SHIFTOUT_EN
    if16.out_req = 1'b0;
    if5.out_req = 1'b0;
`endif
    tbl[0] = '{{16'h0, MSG}, 72, -1, 1'b0, 1'b0, 1'b0, 16'h29B1};
    tbl[1] = '{{16'h0, MSG}, 72, -1, 1'b1, 1'b0, 1'b0, 16'h29B1};
    tbl[2] = '{{MSG, 16'hD64E}, 88, -1, 1'b0, 1'b0, 1'b1, 16'h1D0F};
    tbl[3] = '{{MSG, 16'hD64E}, 88, -1, 1'b1, 1'b0, 1'b1, 16'h1D0F};
    tbl[4] = '{{MSG, 16'hD64E}, 88, -1, 1'b1, 1'b1, 1'b1, 16'h1D0F};
    tbl[5] = '{{MSG, 16'hD64E}, 88, 0, 1'b0, 1'b0, 1'b0, 16'h0};
    tbl[6] = '{{MSG, 16'hD64E}, 88, 45, 1'b0, 1'b1, 1'b0, 16'h0};
    tbl[7] = '{{MSG, 16'hD64E}, 88, 87, 1'b1, 1'b0, 1'b0, 16'h0};
    #12;
    chk("reset crc16", if16.crc, 16'hFFFF);
    chk("reset crc5", if5.crc, 5'b01001);
    chk("reset bit_count", if16.bit_count, 0);
    chk("reset busy/done/ok", {if16.busy, if16.done, if16.crc_ok}, 0);
    reset_n = 1'b1;
    tick;
    foreach (tbl[k]) begin
      send(tbl[k]);
      verdict($sformatf("vec%0d", k));
    end
    if16.bit_valid = 1'b1;
    if16.bit_in = 1'b1;
    repeat (3) tick;
    if16.bit_valid = 1'b0;
    chk("idle ignores bits crc", if16.crc, last.crc);
    chk("idle ignores bits count", if16.bit_count, last.cnt);
    // abort mid-frame: register reloads, no verdict for the abandoned frame
    d = done16;
    if16.start = 1'b1;
    tick;
    if16.start = 1'b0;
    if16.bit_valid = 1'b1;
    repeat (10) tick;
    if16.bit_valid = 1'b0;
    if16.start = 1'b1;
    tick;
    if16.start = 1'b0;
    chk("abort crc", if16.crc, 16'hFFFF);
    chk("abort bit_count", if16.bit_count, 0);
    chk("abort busy", if16.busy, 1);
    repeat (3) tick;
    chk("abort no done", done16 - d, 0);
    push(1'b0, 16'hFFFF, 16'h0);
    if16.frame_end = 1'b1;
    tick;
    if16.frame_end = 1'b0;
    verdict("zero-length16");
    // abort while in CHECK
    d = done16;
    send(tbl[0]);
    void'(sbq.pop_back());
    if16.start = 1'b1;
    tick;
    if16.start = 1'b0;
    repeat (3) tick;
    chk("check-abort no done", done16 - d, 0);
    chk("check-abort busy", if16.busy, 1);
    push(1'b0, 16'hFFFF, 16'h0);
    if16.frame_end = 1'b1;
    tick;
    if16.frame_end = 1'b0;
    verdict("after check-abort");
    // back-to-back: start in the done cycle
    send(tbl[2]);
    void'(sbq.pop_back());
    tick;
    chk("b2b done", if16.done, 1);
    chk("b2b crc_ok", if16.crc_ok, 1);
    chk("b2b crc", if16.crc, 16'h1D0F);
    if16.start = 1'b1;
    tick;
    if16.start = 1'b0;
    chk("b2b restart busy", if16.busy, 1);
    chk("b2b restart crc", if16.crc, 16'hFFFF);
    chk("b2b restart ok cleared", if16.crc_ok, 0);
    push(1'b0, 16'hFFFF, 16'h0);
    if16.frame_end = 1'b1;
    tick;
    if16.frame_end = 1'b0;
    verdict("b2b second");
`ifdef CRC_SHIFTOUT_EN
    send(tbl[0]);
    verdict("shout frame");
    sh = 16'hD64E;
    if16.out_req = 1'b1;
    tick;
    if16.out_req = 1'b0;
    chk("shout first latency", if16.out_valid, 0);
    for (int i = 0; i < 16; i++) begin
      tick;
      chk($sformatf("shout valid%0d", i), if16.out_valid, 1);
      chk($sformatf("shout bit%0d", i), if16.out_bit, sh[15 - i]);
      chk($sformatf("shout last%0d", i), if16.out_last, i == 15);
    end
    tick;
    chk("shout ends", {if16.out_valid, if16.out_last}, 0);
    chk("shout keeps crc", if16.crc, 16'h29B1);
    if16.start = 1'b1;
    if16.out_req = 1'b1;
    tick;
    {if16.start, if16.out_req} = 2'b00;
    chk("start beats out_req busy", if16.busy, 1);
    chk("start beats out_req valid", if16.out_valid, 0);
    tick;
    chk("start beats out_req valid2", if16.out_valid, 0);
    push(1'b0, 16'hFFFF, 16'h0);
    if16.frame_end = 1'b1;
    tick;
    if16.frame_end = 1'b0;
    verdict("after start+out_req");
`endif
    // CRC-5: single 1 bit, then zero-length frame
    if5.start = 1'b1;
    tick;
    if5.start = 1'b0;
    if5.bit_valid = 1'b1;
    if5.bit_in = 1'b1;
    tick;
    if5.bit_valid = 1'b0;
    chk("crc5 one bit", if5.crc, 5'b11011);
    chk("crc5 bit_count", if5.bit_count, 1);
    d = done5;
    if5.frame_end = 1'b1;
    tick;
    if5.frame_end = 1'b0;
    tick;
    chk("crc5 done", if5.done, 1);
    chk("crc5 ok", if5.crc_ok, 0);
    if5.start = 1'b1;
    tick;
    if5.start = 1'b0;
    if5.frame_end = 1'b1;
    tick;
    if5.frame_end = 1'b0;
    tick;
    chk("crc5 zero-len done", if5.done, 1);
    chk("crc5 zero-len crc", if5.crc, 5'b01001);
    chk("crc5 zero-len ok", if5.crc_ok, 0);
    tick;
    chk("crc5 done count", done5 - d, 2);
    // asynchronous reset in the middle of a frame
    d = done16;
    if16.start = 1'b1;
    tick;
    if16.start = 1'b0;
    if16.bit_valid = 1'b1;
    if16.bit_in = 1'b1;
    tick;
    tick;
    if16.bit_valid = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("async reset crc", if16.crc, 16'hFFFF);
    chk("async reset count", if16.bit_count, 0);
    chk("async reset busy/done/ok", {if16.busy, if16.done, if16.crc_ok}, 0);
`ifdef CRC_SHIFTOUT_EN
    chk("async reset shout", {if16.out_valid, if16.out_last, if16.out_bit}, 0);
`endif
    tick;
    reset_n = 1'b1;
    if16.frame_end = 1'b1;
    tick;
    if16.frame_end = 1'b0;
    repeat (3) tick;
    chk("reset discards frame", done16 - d, 0);
    chk("reset leaves idle", if16.busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/crc_frame_engine.md
# crc_frame_engine

Parametrised serial CRC generator/checker for the tag datapath; it replaces the fixed 5-bit checker with one engine that covers CRC-5 and CRC-16 framing. It consumes demodulated reader bits one per qualified cycle and reports a registered pass/fail verdict at frame end. Optionally, it serialises the computed CRC out MSB-first for the tag backscatter encoder.

## Interface

Parameters:
- `WIDTH`, 16: CRC register width; legal values 5 or 16.
- `POLY`, 16'h1021: generator polynomial, implicit x^WIDTH term omitted; use 5'h09 for CRC-5.
- `PRESET`, 16'hFFFF: register value at frame start; use 5'b01001 for CRC-5.
- `RESIDUE`, 16'h1D0F: register value that signals a good frame after data plus received CRC; use 5'h00 for CRC-5.
- `INVERT_OUT`, 1: 1 means the transmitted CRC is the ones-complement of the register; use 0 for CRC-5.

Ports:
- `crcclk`, in, 1: sole clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: frame start pulse; reloads `PRESET`.
- `bit_valid`, in, 1: qualifies `bit_in` this cycle.
- `bit_in`, in, 1: serial data bit, MSB-first.
- `frame_end`, in, 1: last bit has been delivered; requests the verdict.
- `crc`, out, WIDTH: live CRC register.
- `busy`, out, 1: engine is in SHIFT.
- `done`, out, 1: one-cycle verdict pulse.
- `crc_ok`, out, 1: verdict; held until the next `start`.
- `bit_count`, out, 16: qualified bits accepted this frame; saturates at 16'hFFFF.
- `out_req`, in, 1: start serialising the CRC (only with `CRC_SHIFTOUT_EN`).
- `out_bit`, `out_valid`, `out_last`, out, 1 each: serial CRC output (only with `CRC_SHIFTOUT_EN`).

## Operation

- **States:** IDLE, SHIFT, CHECK, and SHOUT (SHOUT exists only with the macro).
- **IDLE:**
  - `start` loads `crc` with `PRESET`, clears `bit_count` and `crc_ok`, and moves to SHIFT.
  - `bit_valid` is ignored in IDLE.
- **SHIFT:** on each `bit_valid`, let `fb = bit_in ^ crc[WIDTH-1]`. Then `crc <= {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)`, and `bit_count` increments.
- **frame_end in SHIFT:**
  - The engine moves to CHECK.
  - If `bit_valid` is asserted in the same cycle, that bit is absorbed first.
- **CHECK (one cycle):**
  - `crc_ok <= (crc == RESIDUE)` and `done` pulses.
  - The engine returns to IDLE; `crc` keeps its value.
- **start while SHIFT or CHECK:** abandons the frame and reloads `PRESET`. No `done` pulse is emitted for the abandoned frame.
- **SHOUT:**
  - Entered from IDLE on `out_req`.
  - Emits `WIDTH` bits, one per cycle, MSB-first. Each bit is `crc[WIDTH-1-i] ^ INVERT_OUT`.
  - `out_valid` is high throughout SHOUT; `out_last` is high on bit index `WIDTH-1`.
  - `crc` is not modified. SHOUT uses a separate index counter, so the register stays readable.
  - `out_req` outside IDLE is ignored.
- **Simultaneous requests in IDLE:** `start` has priority over `out_req`.
- **Parameter legality:** `WIDTH` other than 5 or 16 is an elaboration error (generate-time `$error`).

## Timing

- **Reset values:** `reset_n` low asynchronously forces:
  - state IDLE
  - `crc = PRESET`
  - `bit_count = 0`
  - `busy`, `done`, `crc_ok` = 0
  - `out_valid`, `out_last`, `out_bit` = 0
- **Reset release:** takes effect on the first `crcclk` edge after deassertion.
- **Bit latency:** a bit sampled at edge N is reflected in `crc` after edge N.
- **Verdict latency:** `frame_end` at edge N gives `done`/`crc_ok` valid after edge N+1.
- **Back-to-back frames:** `start` is legal in the cycle where `done` is high.
- **Shift-out:** `out_req` at edge N gives the first `out_valid` after edge N+1. `out_last` is high after edge N+WIDTH.
- **Mid-frame reset:** discards the frame without a `done` pulse.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- **Macro:** `CRC_SHIFTOUT_EN`.
- **Defined:**
  - The SHOUT state, its index counter, `out_req`, `out_bit`, `out_valid` and `out_last` are present.
- **Undefined:**
  - The four shift-out ports are absent from the port list.
  - SHOUT is not synthesised. `crc` remains a parallel output for the encoder.

## Test plan

- **CRC-16, ASCII "123456789" (72 bits, MSB-first):** after `frame_end`, `crc` = 16'h29B1. With the macro, shift-out emits 16'hD64E with `out_last` on the 16th bit.
- **CRC-16 residue:** feed "123456789" then 16'hD64E (88 bits) → `crc` = 16'h1D0F, `crc_ok` = 1, one `done` pulse, `bit_count` = 88. Flipping any one bit → `crc_ok` = 0.
- **CRC-5 (`WIDTH` 5, `POLY` 5'h09, `PRESET` 5'b01001):**
  - `start`, then a single bit 1 → `crc` = 5'b11011.
  - Zero-length frame (`start` then `frame_end`) → `crc` = 5'b01001 and `crc_ok` = 0.
- **Gaps and concurrency:** `bit_valid` deasserted for random gaps mid-frame → results identical to the gapless run. `bit_valid` together with `frame_end` → the final bit is absorbed.
- **Abort:** `start` mid-frame → `crc` = `PRESET` and `bit_count` = 0 on the next cycle, with no `done`.
- **Reset:** `reset_n` asserted mid-frame, asynchronously between clock edges → all outputs immediately take their reset values. `start` and `out_req` in the same cycle → `start` wins and `out_valid` stays 0.
